// File: rtl/iir_seq_ctrl.sv
// Run sequencer for a single myiir filter: shadow/active coefficient banks, filter
// clear pulse, gap-paced sample feed, output counting with a drain watchdog.
module iir_seq_ctrl #(
    parameter int NB     = 13,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 4,
    parameter int TO_CYC = 64
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_ADDR,
    input  logic [NB-1:0]    CFG_DATA,
    input  logic             START,
    input  logic [CNT_W-1:0] NSAMP,
    input  logic             SRC_VALID,
    input  logic [NB-1:0]    SRC_DATA,
    output logic             SRC_READY,
    output logic             FLT_RST_n,
    output logic [NB-1:0]    FLT_DIN,
    output logic             FLT_VIN,
    output logic [NB-1:0]    FLT_A1,
    output logic [NB-1:0]    FLT_B0,
    output logic [NB-1:0]    FLT_B1,
    input  logic             FLT_VOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int WD_W = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic              clr_cnt_q, clr_cnt_d;
    logic [NB-1:0]     a1_sh_q, a1_sh_d;
    logic [NB-1:0]     b0_sh_q, b0_sh_d;
    logic [NB-1:0]     b1_sh_q, b1_sh_d;
    logic [GAP_W-1:0]  gap_sh_q, gap_sh_d;
    logic [NB-1:0]     a1_q, a1_d;
    logic [NB-1:0]     b0_q, b0_d;
    logic [NB-1:0]     b1_q, b1_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  nsamp_q, nsamp_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [NB-1:0]     flt_din_q, flt_din_d;
    logic              flt_vin_q, flt_vin_d;
    logic              flt_rst_n_q, flt_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              src_ready;

    assign src_ready = (state_q == S_FEED) && (gap_cnt_q == '0) && (in_cnt_q < nsamp_q);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        a1_sh_d   = a1_sh_q;
        b0_sh_d   = b0_sh_q;
        b1_sh_d   = b1_sh_q;
        gap_sh_d  = gap_sh_q;
        a1_d      = a1_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        gap_d     = gap_q;
        nsamp_d   = nsamp_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        gap_cnt_d = gap_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        flt_din_d = flt_din_q;
        flt_vin_d = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        // Filter outputs are only meaningful while a run is streaming or draining.
        if (FLT_VOUT && ((state_q == S_FEED) || (state_q == S_DRAIN))) begin
            if (out_cnt_q == nsamp_q) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (CFG_WE) begin
                    case (CFG_ADDR)
                        2'd0:    a1_sh_d  = CFG_DATA;
                        2'd1:    b0_sh_d  = CFG_DATA;
                        2'd2:    b1_sh_d  = CFG_DATA;
                        default: gap_sh_d = CFG_DATA[GAP_W-1:0];
                    endcase
                end
                if (START) begin
                    err_d = 1'b0;
                    if (NSAMP != '0) begin
                        a1_d      = a1_sh_q;
                        b0_d      = b0_sh_q;
                        b1_d      = b1_sh_q;
                        gap_d     = gap_sh_q;
                        nsamp_d   = NSAMP;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        gap_cnt_d = '0;
                        clr_cnt_d = 1'b0;
                        state_d   = S_CLEAR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                clr_cnt_d = 1'b1;
                if (clr_cnt_q) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
                if (SRC_VALID && src_ready) begin
                    flt_din_d = SRC_DATA;
                    flt_vin_d = 1'b1;
                    in_cnt_d  = in_cnt_q + CNT_W'(1);
                    gap_cnt_d = gap_q;
                    if (in_cnt_q + CNT_W'(1) == nsamp_q) begin
                        wd_cnt_d = WD_LOAD;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (FLT_VOUT) begin
                    wd_cnt_d = WD_LOAD;
                end else if (wd_cnt_q <= WD_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_cnt_d = wd_cnt_q - WD_W'(1);
                end
                if (out_cnt_d == nsamp_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status and filter reset are registered from the next state so they are glitch-free.
        busy_d      = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d      = done_d || (state_d == S_FIN);
        flt_rst_n_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= 1'b0;
            a1_sh_q     <= '0;
            b0_sh_q     <= '0;
            b1_sh_q     <= '0;
            gap_sh_q    <= '0;
            a1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            gap_q       <= '0;
            nsamp_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            flt_din_q   <= '0;
            flt_vin_q   <= 1'b0;
            flt_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            a1_sh_q     <= a1_sh_d;
            b0_sh_q     <= b0_sh_d;
            b1_sh_q     <= b1_sh_d;
            gap_sh_q    <= gap_sh_d;
            a1_q        <= a1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            gap_q       <= gap_d;
            nsamp_q     <= nsamp_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            flt_din_q   <= flt_din_d;
            flt_vin_q   <= flt_vin_d;
            flt_rst_n_q <= flt_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign SRC_READY = src_ready;
    assign FLT_RST_n = flt_rst_n_q;
    assign FLT_DIN   = flt_din_q;
    assign FLT_VIN   = flt_vin_q;
    assign FLT_A1    = a1_q;
    assign FLT_B0    = b0_q;
    assign FLT_B1    = b1_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Directed bench for iir_seq_ctrl: table of complete runs plus hand-written sequences
// for reset abort, source stalls, config writes while busy and surplus filter outputs.
module tb_iir_seq_ctrl;

    localparam int NB    = 13;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b0;
    logic             CFG_WE = 1'b0;
    logic [1:0]       CFG_ADDR = '0;
    logic [NB-1:0]    CFG_DATA = '0;
    logic             START = 1'b0;
    logic [CNT_W-1:0] NSAMP = '0;
    logic             SRC_VALID = 1'b0;
    logic [NB-1:0]    SRC_DATA = '0;
    logic             SRC_READY;
    logic             FLT_RST_n;
    logic [NB-1:0]    FLT_DIN;
    logic             FLT_VIN;
    logic [NB-1:0]    FLT_A1;
    logic [NB-1:0]    FLT_B0;
    logic [NB-1:0]    FLT_B1;
    logic             FLT_VOUT = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    iir_seq_ctrl dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .CFG_WE    (CFG_WE),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_DATA  (CFG_DATA),
        .START     (START),
        .NSAMP     (NSAMP),
        .SRC_VALID (SRC_VALID),
        .SRC_DATA  (SRC_DATA),
        .SRC_READY (SRC_READY),
        .FLT_RST_n (FLT_RST_n),
        .FLT_DIN   (FLT_DIN),
        .FLT_VIN   (FLT_VIN),
        .FLT_A1    (FLT_A1),
        .FLT_B0    (FLT_B0),
        .FLT_B1    (FLT_B1),
        .FLT_VOUT  (FLT_VOUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    // 100 MHz clock
    initial begin
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [NB-1:0]    a1, b0, b1;
        logic [3:0]       gap;
        logic [CNT_W-1:0] nsamp;
        int               drop_idx;
        logic             exp_err;
        int               exp_vin;
        int               exp_rst_low;
        logic [NB-1:0]    exp_a1, exp_b0, exp_b1;
        int               lat_min, lat_max;
    } run_vec_t;

    run_vec_t vecs[6];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vin_cnt, hs_cnt, done_cnt, rst_low_cnt, busy_cnt, data_err;
    int min_space, max_space, last_vin_cyc, last_vout_cyc, start_cyc, done_lat;
    int drop_idx = 0;
    int src_base = 0;
    bit lat_ref_start = 1'b0;
    bit force_vout = 1'b0;
    logic [2:0] pipe = '0;

    function automatic logic [NB-1:0] data_of(input int i);
        return NB'(src_base + i * 37);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic reset_monitors();
        vin_cnt = 0; hs_cnt = 0; done_cnt = 0; rst_low_cnt = 0; busy_cnt = 0; data_err = 0;
        min_space = 1000; max_space = 0; last_vin_cyc = -1; last_vout_cyc = 0;
        done_lat = -1; pipe = '0; force_vout = 1'b0; FLT_VOUT = 1'b0;
        SRC_DATA = data_of(0);
    endtask

    // One clock: handshake bookkeeping, output monitors, then the latency-2 filter model.
    task automatic tick();
        bit hs_pre;
        int sp;
        hs_pre = (SRC_VALID === 1'b1) && (SRC_READY === 1'b1);
        @(posedge CLK);
        #1;
        cyc++;
        if (hs_pre) begin
            hs_cnt++;
            SRC_DATA = data_of(hs_cnt);
        end
        if (FLT_VIN === 1'b1) begin
            vin_cnt++;
            if (FLT_DIN !== data_of(vin_cnt - 1)) data_err++;
            if (last_vin_cyc >= 0) begin
                sp = cyc - last_vin_cyc;
                if (sp < min_space) min_space = sp;
                if (sp > max_space) max_space = sp;
            end
            last_vin_cyc = cyc;
        end
        if (DONE === 1'b1) begin
            done_cnt++;
            done_lat = cyc - (lat_ref_start ? start_cyc : last_vout_cyc);
        end
        if (FLT_RST_n === 1'b0) rst_low_cnt++;
        if (BUSY === 1'b1) busy_cnt++;
        pipe = {pipe[1:0], (FLT_VIN === 1'b1) && (vin_cnt != drop_idx)};
        FLT_VOUT = pipe[2] | force_vout;
        if (FLT_VOUT) last_vout_cyc = cyc;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [NB-1:0] data);
        CFG_WE = 1'b1;
        CFG_ADDR = addr;
        CFG_DATA = data;
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        NSAMP = n;
        START = 1'b1;
        start_cyc = cyc;
        tick();
        START = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick();
    endtask

    task automatic applyStimulus(input int idx, input run_vec_t v);
        src_base = 200 * (idx + 1);
        drop_idx = v.drop_idx;
        reset_monitors();
        cfg_write(2'd0, v.a1);
        cfg_write(2'd1, v.b0);
        cfg_write(2'd2, v.b1);
        cfg_write(2'd3, NB'(v.gap));
        SRC_VALID = 1'b1;
        lat_ref_start = (v.nsamp == 0);
        start_run(v.nsamp);
        run_until_done(400);
        repeat (4) tick();
        SRC_VALID = 1'b0;
        drop_idx = 0;
        $display("[TB] run %0d nsamp=%0d gap=%0d done_lat=%0d", idx, v.nsamp, v.gap, done_lat);
        checkOutput($sformatf("run%0d_done_count", idx), done_cnt, 1);
        checkOutput($sformatf("run%0d_err", idx), ERR, v.exp_err);
        checkOutput($sformatf("run%0d_vin_count", idx), vin_cnt, v.exp_vin);
        checkOutput($sformatf("run%0d_vin_data", idx), data_err, 0);
        checkOutput($sformatf("run%0d_flt_rst_low", idx), rst_low_cnt, v.exp_rst_low);
        checkOutput($sformatf("run%0d_busy_seen", idx), busy_cnt != 0, v.nsamp != 0);
        checkOutput($sformatf("run%0d_a1", idx), FLT_A1, v.exp_a1);
        checkOutput($sformatf("run%0d_b0", idx), FLT_B0, v.exp_b0);
        checkOutput($sformatf("run%0d_b1", idx), FLT_B1, v.exp_b1);
        checkOutput($sformatf("run%0d_done_latency_ok", idx),
                    (done_lat >= v.lat_min) && (done_lat <= v.lat_max), 1);
        checkOutput($sformatf("run%0d_busy_after", idx), BUSY, 0);
        if (v.nsamp >= 2) begin
            checkOutput($sformatf("run%0d_min_vin_spacing", idx), min_space, v.gap + 1);
            checkOutput($sformatf("run%0d_max_vin_spacing", idx), max_space, v.gap + 1);
        end
    endtask

    initial begin
        vecs[0] = '{13'h0100, 13'h0200, 13'h0300, 4'd0, 16'd4, 0, 1'b0, 4, 2,
                    13'h0100, 13'h0200, 13'h0300, 1, 1};
        vecs[1] = '{13'h0AAA, 13'h1555, 13'h0001, 4'd2, 16'd3, 0, 1'b0, 3, 2,
                    13'h0AAA, 13'h1555, 13'h0001, 1, 1};
        vecs[2] = '{13'h0111, 13'h0222, 13'h0333, 4'd0, 16'd0, 0, 1'b0, 0, 0,
                    13'h0AAA, 13'h1555, 13'h0001, 1, 1};
        vecs[3] = '{13'h0123, 13'h0456, 13'h0789, 4'd0, 16'd2, 2, 1'b1, 2, 2,
                    13'h0123, 13'h0456, 13'h0789, 64, 66};
        vecs[4] = '{13'h1FFF, 13'h0000, 13'h1000, 4'd5, 16'd1, 0, 1'b0, 1, 2,
                    13'h1FFF, 13'h0000, 13'h1000, 1, 1};
        vecs[5] = '{13'h0010, 13'h0020, 13'h0030, 4'd1, 16'd5, 0, 1'b0, 5, 2,
                    13'h0010, 13'h0020, 13'h0030, 1, 1};

        // Power-on reset state, then release between clock edges
        #3;
        checkOutput("por_flt_rst_n", FLT_RST_n, 0);
        checkOutput("por_busy", BUSY, 0);
        checkOutput("por_done", DONE, 0);
        checkOutput("por_err", ERR, 0);
        checkOutput("por_vin", FLT_VIN, 0);
        checkOutput("por_a1", FLT_A1, 0);
        checkOutput("por_src_ready", SRC_READY, 0);
        #19;
        RST_n = 1'b1;
        reset_monitors();
        tick();
        checkOutput("por_release_flt_rst_n", FLT_RST_n, 1);

        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        // Source stalls mid-run with GAP=3
        src_base = 3000;
        reset_monitors();
        cfg_write(2'd3, NB'(3));
        SRC_VALID = 1'b1;
        lat_ref_start = 1'b0;
        start_run(16'd3);
        for (int k = 0; k < 20 && hs_cnt == 0; k++) tick();
        checkOutput("t3_first_accept", hs_cnt, 1);
        repeat (5) tick();
        SRC_VALID = 1'b0;
        repeat (6) tick();
        SRC_VALID = 1'b1;
        run_until_done(200);
        repeat (4) tick();
        SRC_VALID = 1'b0;
        checkOutput("t3_done", done_cnt, 1);
        checkOutput("t3_vin_count", vin_cnt, 3);
        checkOutput("t3_vin_data", data_err, 0);
        checkOutput("t3_spacing_ge4", min_space >= 4, 1);
        checkOutput("t3_err", ERR, 0);

        // Config write while busy must not reach active or shadow coefficients
        src_base = 3500;
        reset_monitors();
        cfg_write(2'd0, 13'h0100);
        cfg_write(2'd3, NB'(1));
        SRC_VALID = 1'b1;
        start_run(16'd3);
        cfg_write(2'd0, 13'h1FFF);
        checkOutput("t4_busy_during_write", BUSY, 1);
        checkOutput("t4_a1_during_run", FLT_A1, 13'h0100);
        run_until_done(200);
        repeat (4) tick();
        checkOutput("t4_done", done_cnt, 1);
        checkOutput("t4_a1_after_run", FLT_A1, 13'h0100);
        reset_monitors();
        start_run(16'd1);
        run_until_done(200);
        repeat (4) tick();
        SRC_VALID = 1'b0;
        checkOutput("t4_next_run_done", done_cnt, 1);
        checkOutput("t4_next_run_a1", FLT_A1, 13'h0100);
        checkOutput("t4_next_run_err", ERR, 0);

        // Surplus filter outputs during FEED saturate the count and raise ERR
        src_base = 4000;
        reset_monitors();
        cfg_write(2'd3, NB'(0));
        start_run(16'd2);
        for (int k = 0; k < 10 && SRC_READY !== 1'b1; k++) tick();
        checkOutput("t6x_in_feed", SRC_READY, 1);
        force_vout = 1'b1;
        repeat (3) tick();
        force_vout = 1'b0;
        tick();
        checkOutput("t6x_err_mid_run", ERR, 1);
        checkOutput("t6x_busy_mid_run", BUSY, 1);
        SRC_VALID = 1'b1;
        run_until_done(200);
        repeat (4) tick();
        SRC_VALID = 1'b0;
        checkOutput("t6x_done", done_cnt, 1);
        checkOutput("t6x_err_final", ERR, 1);
        checkOutput("t6x_vin_count", vin_cnt, 2);

        // Asynchronous reset in the middle of FEED aborts the run
        src_base = 4500;
        reset_monitors();
        cfg_write(2'd3, NB'(3));
        SRC_VALID = 1'b1;
        start_run(16'd8);
        for (int k = 0; k < 20 && vin_cnt == 0; k++) tick();
        checkOutput("t1_run_started", vin_cnt, 1);
        #3;
        RST_n = 1'b0;
        #1;
        checkOutput("t1_async_flt_rst_n", FLT_RST_n, 0);
        checkOutput("t1_async_busy", BUSY, 0);
        checkOutput("t1_async_a1", FLT_A1, 0);
        checkOutput("t1_async_din", FLT_DIN, 0);
        checkOutput("t1_async_src_ready", SRC_READY, 0);
        tick();
        tick();
        checkOutput("t1_held_flt_rst_n", FLT_RST_n, 0);
        #2;
        RST_n = 1'b1;
        reset_monitors();
        tick();
        checkOutput("t1_release_flt_rst_n", FLT_RST_n, 1);
        repeat (10) tick();
        SRC_VALID = 1'b0;
        checkOutput("t1_no_done", done_cnt, 0);
        checkOutput("t1_idle_busy", BUSY, 0);

        // Shadow registers were cleared by reset
        reset_monitors();
        SRC_VALID = 1'b1;
        start_run(16'd1);
        run_until_done(200);
        repeat (4) tick();
        SRC_VALID = 1'b0;
        checkOutput("post_reset_done", done_cnt, 1);
        checkOutput("post_reset_a1", FLT_A1, 0);
        checkOutput("post_reset_vin", vin_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
